// File: rtl/emu_time_pkg.sv
// emu_time_pkg: shared state and command encodings for the emulator time controller
// Contents: state_t (controller state as seen on state_o), cmd_op_t (host command opcodes)
package emu_time_pkg;
    typedef enum logic [1:0] {
        ST_RSTSEQ = 2'd0,
        ST_IDLE   = 2'd1,
        ST_RUN    = 2'd2,
        ST_STEP   = 2'd3
    } state_t;
    typedef enum logic [1:0] {
        OP_RUN   = 2'd0,
        OP_STOP  = 2'd1,
        OP_STEP  = 2'd2,
        OP_CLEAR = 2'd3
    } cmd_op_t;
endpackage

// File: rtl/emu_time_acc.sv
// emu_time_acc: emulated-time accumulator with sticky carry-out overflow
// Ports: emu_clk/emu_rst (async active-high), en adds dt this cycle, clr zeroes time and overflow,
//        dt timestep (zero-extended), emu_time accumulated time, time_ovf sticky carry flag
module emu_time_acc
    import emu_time_pkg::*;
#(
    parameter int TIME_WIDTH = 32,
    parameter int DT_WIDTH   = 16
) (
    input  logic                  emu_clk,
    input  logic                  emu_rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic [DT_WIDTH-1:0]   dt,
    output logic [TIME_WIDTH-1:0] emu_time,
    output logic                  time_ovf
);
    logic [TIME_WIDTH:0] sum;
    assign sum = {1'b0, emu_time} + (TIME_WIDTH+1)'(dt);
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            emu_time <= '0;
            time_ovf <= 1'b0;
        end else if (clr) begin
            emu_time <= '0;
            time_ovf <= 1'b0;
        end else if (en) begin
            emu_time <= sum[TIME_WIDTH-1:0];
            time_ovf <= time_ovf | sum[TIME_WIDTH];
        end
    end
endmodule

// File: rtl/emu_time_ctrl.sv
// emu_time_ctrl: run/stop/step controller producing the model clock enable, model reset and emulated time
// Ports: emu_clk/emu_rst (async active-high); cmd_valid/cmd_ready/cmd_op/cmd_arg host command handshake;
//        dt_req timestep latched on RUN/STEP; emu_ce, model_rst, emu_dt, emu_time, time_ovf, done, state_o outputs.
// Option: EMU_TSTOP_EN adds input t_stop; an enabled cycle whose emu_time+emu_dt reaches t_stop is the last one.
module emu_time_ctrl
    import emu_time_pkg::*;
#(
    parameter int TIME_WIDTH = 32,
    parameter int DT_WIDTH   = 16,
    parameter int STEP_WIDTH = 16,
    parameter int RST_CYCLES = 4
) (
    input  logic                  emu_clk,
    input  logic                  emu_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [STEP_WIDTH-1:0] cmd_arg,
    input  logic [DT_WIDTH-1:0]   dt_req,
`ifdef EMU_TSTOP_EN
    input  logic [TIME_WIDTH-1:0] t_stop,
`endif
    output logic                  emu_ce,
    output logic                  model_rst,
    output logic [DT_WIDTH-1:0]   emu_dt,
    output logic [TIME_WIDTH-1:0] emu_time,
    output logic                  time_ovf,
    output logic                  done,
    output logic [1:0]            state_o
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    state_t                state;
    logic [RW-1:0]         rcnt;
    logic [STEP_WIDTH-1:0] scnt;
    logic                  accept;
    logic                  clr;
    logic                  last_ce;
    assign cmd_ready = state != ST_RSTSEQ;
    assign accept    = cmd_valid && cmd_ready;
    assign clr       = accept && cmd_op_t'(cmd_op) == OP_CLEAR;
    assign state_o   = state;
`ifdef EMU_TSTOP_EN
    // Compare the untruncated next time so a wrapping sum still counts as reaching t_stop.
    logic [TIME_WIDTH:0] nxt_time;
    assign nxt_time = {1'b0, emu_time} + (TIME_WIDTH+1)'(emu_dt);
    assign last_ce  = emu_ce && nxt_time >= {1'b0, t_stop};
`else
    assign last_ce  = 1'b0;
`endif
    // Accepted commands take priority over step completion and t_stop, which suppresses done.
    always_ff @(posedge emu_clk or posedge emu_rst) begin
        if (emu_rst) begin
            state     <= ST_RSTSEQ;
            rcnt      <= RW'(RST_CYCLES);
            scnt      <= '0;
            emu_ce    <= 1'b0;
            model_rst <= 1'b1;
            emu_dt    <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                case (cmd_op_t'(cmd_op))
                    OP_RUN: begin
                        state  <= ST_RUN;
                        emu_dt <= dt_req;
                        emu_ce <= 1'b1;
                    end
                    OP_STOP: begin
                        state  <= ST_IDLE;
                        emu_ce <= 1'b0;
                    end
                    OP_STEP: begin
                        emu_dt <= dt_req;
                        scnt   <= cmd_arg;
                        state  <= cmd_arg == '0 ? ST_IDLE : ST_STEP;
                        emu_ce <= cmd_arg != '0;
                        done   <= cmd_arg == '0;
                    end
                    OP_CLEAR: begin
                        state     <= ST_RSTSEQ;
                        rcnt      <= RW'(RST_CYCLES);
                        model_rst <= 1'b1;
                        emu_ce    <= 1'b0;
                    end
                endcase
            end else begin
                case (state)
                    ST_RSTSEQ: begin
                        rcnt <= rcnt - RW'(1);
                        if (rcnt == RW'(1)) begin
                            state     <= ST_IDLE;
                            model_rst <= 1'b0;
                        end
                    end
                    ST_RUN: if (last_ce) begin
                        state  <= ST_IDLE;
                        emu_ce <= 1'b0;
                        done   <= 1'b1;
                    end
                    ST_STEP: begin
                        scnt <= scnt - STEP_WIDTH'(1);
                        if (scnt == STEP_WIDTH'(1) || last_ce) begin
                            state  <= ST_IDLE;
                            emu_ce <= 1'b0;
                            done   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
    emu_time_acc #(
        .TIME_WIDTH(TIME_WIDTH),
        .DT_WIDTH  (DT_WIDTH)
    ) u_acc (
        .emu_clk (emu_clk),
        .emu_rst (emu_rst),
        .en      (emu_ce),
        .clr     (clr),
        .dt      (emu_dt),
        .emu_time(emu_time),
        .time_ovf(time_ovf)
    );
endmodule
